// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq datapath: op codes, handshake states and op classification.
// Used by alu_seq and alu_muldiv_iter.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LUI   = 4'b0011;
    localparam logic [3:0] OP_SLTS  = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per clock.
// hi/lo share one double-width shift register; done is raised once all WIDTH steps are complete.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   b_q;
    logic               div_q;
    logic               dbz_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    assign last = busy_q && (cnt_q == CNT_W'(WIDTH));

    // A zero divisor needs no special case: every trial succeeds, so the
    // quotient fills with ones and the dividend shifts whole into the remainder.
    always_comb begin
        addend  = p_q[0] ? b_q : '0;
        add_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        shifted = p_q[2*WIDTH-1:WIDTH-1];
        trial   = shifted - {1'b0, b_q};
        p_d     = p_q;
        if (div_q) begin
            if (shifted >= {1'b0, b_q}) begin
                p_d = {trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
            end else begin
                p_d = {shifted[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            p_d = {add_sum, p_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q    <= '0;
            b_q    <= '0;
            div_q  <= 1'b0;
            dbz_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            p_q    <= {{WIDTH{1'b0}}, a};
            b_q    <= b;
            div_q  <= (op == OP_DIVU);
            dbz_q  <= (op == OP_DIVU) && (b == '0);
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            if (last) begin
                busy_q <= 1'b0;
            end else begin
                p_q   <= p_d;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = last;
    assign hi          = p_q[2*WIDTH-1:WIDTH];
    assign lo          = p_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: registered single-cycle ops plus iterative MULTU/DIVU.
// Optional signed-overflow output ovf is built when ALU_SEQ_OVF_EN is defined.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
`ifdef ALU_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             div_by_zero
);

    localparam int unsigned HALF = WIDTH / 2;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             dbz_q;

    logic             accept;
    logic             accept_mc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic             md_dbz;

    assign accept    = in_valid && in_ready;
    assign accept_mc = accept && is_multicycle(op);

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept_mc),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (md_busy),
        .done       (md_done),
        .hi         (md_hi),
        .lo         (md_lo),
        .div_by_zero(md_dbz)
    );

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LUI:  alu_res = {b[HALF-1:0], {HALF{1'b0}}};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLTS: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A transfer out of DONE may coincide with a new acceptance, so DONE can
    // step straight to BUSY or back into DONE without visiting IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = accept_mc ? BUSY : DONE;
            end
            BUSY: begin
                if (md_done)       state_d = DONE;
                else if (!md_busy) state_d = IDLE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) state_d = accept_mc ? BUSY : DONE;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else if (accept && !accept_mc) begin
            result_q    <= alu_res;
            result_hi_q <= '0;
            zero_q      <= (alu_res == '0);
            dbz_q       <= 1'b0;
        end else if ((state_q == BUSY) && md_done) begin
            result_q    <= md_lo;
            result_hi_q <= md_hi;
            zero_q      <= (md_lo == '0);
            dbz_q       <= md_dbz;
        end
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept && !accept_mc) begin
            ovf_q <= alu_ovf;
        end else if ((state_q == BUSY) && md_done) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = alu_ovf;
`endif

    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32 (covers ovf when ALU_SEQ_OVF_EN is defined).
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         div_by_zero;
`ifdef ALU_SEQ_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    alu_seq #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .zero       (zero),
`ifdef ALU_SEQ_OVF_EN
        .ovf        (ovf),
`endif
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for exactly one acceptance edge; returns 1 ns after it.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        #1;
        check("in_ready_at_issue", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Counts clocks until out_valid, noting any in_ready seen while waiting.
    task automatic wait_out(output int n, output bit rdy_seen);
        n        = 0;
        rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && n < 60) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            a = a ^ 32'h5A5A_A5A5;
            b = b + 32'd3;
            tick();
            n++;
        end
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] lo, input logic [W-1:0] hi,
                              input logic z, input logic dz);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_result"}, 64'(result), 64'(lo));
        check({tag, "_result_hi"}, 64'(result_hi), 64'(hi));
        check({tag, "_zero"}, 64'(zero), 64'(z));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(dz));
    endtask

    initial begin
        int  n;
        bit  rdy_seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 4'b0000;
        a         = '0;
        b         = '0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_result_hi", 64'(result_hi), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single-cycle ops: result visible one clock after acceptance.
        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_out("add_wrap", 32'h0000_0000, 32'h0, 1'b1, 1'b0);
        tick();
        check("idle_after_xfer", 64'(out_valid), 64'd0);
        issue(4'b0011, 32'hDEAD_BEEF, 32'h0000_1234);
        expect_out("lui", 32'h1234_0000, 32'h0, 1'b0, 1'b0);
        tick();
        issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_out("slt", 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        issue(4'b0100, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_out("slts", 32'h1, 32'h0, 1'b0, 1'b0);
        tick();
        issue(4'b0110, 32'h0000_0005, 32'h0000_0007);
        expect_out("sub", 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0);
        tick();
        issue(4'b0000, 32'hF0F0_1234, 32'hFF00_00FF);
        expect_out("and", 32'hF000_0034, 32'h0, 1'b0, 1'b0);
        tick();
        issue(4'b0101, 32'hF0F0_0000, 32'h0F00_000F);
        expect_out("nor", 32'h000F_FFF0, 32'h0, 1'b0, 1'b0);
        tick();
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        expect_out("undef_op", 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // MULTU: WIDTH+1 clocks of latency, in_ready low throughout BUSY.
        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        op       = 4'b0010;
        wait_out(n, rdy_seen);
        in_valid = 1'b0;
        check("mul_latency", 64'(n), 64'd33);
        check("mul_busy_in_ready", 64'(rdy_seen), 64'd0);
        expect_out("mul_max", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
        tick();
        issue(4'b1000, 32'h1234_5678, 32'h0000_0010);
        wait_out(n, rdy_seen);
        expect_out("mul_shift", 32'h2345_6780, 32'h0000_0001, 1'b0, 1'b0);
        tick();

        // DIVU cases including divide-by-zero and a zero quotient.
        issue(4'b1001, 32'd100, 32'd7);
        wait_out(n, rdy_seen);
        check("div_latency", 64'(n), 64'd33);
        expect_out("div", 32'd14, 32'd2, 1'b0, 1'b0);
        tick();
        issue(4'b1001, 32'd5, 32'd0);
        wait_out(n, rdy_seen);
        expect_out("div0", 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1);
        tick();
        issue(4'b1001, 32'd7, 32'd100);
        wait_out(n, rdy_seen);
        expect_out("div_small", 32'd0, 32'd7, 1'b1, 1'b0);
        tick();

        // Backpressure in DONE, then release with a same-edge reload.
        out_ready = 1'b0;
        issue(4'b1010, 32'h0000_F0F0, 32'h0000_FF00);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(result), 64'h0000_0FF0);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        issue(4'b0001, 32'h0000_000F, 32'h0000_00F0);
        expect_out("reload_or", 32'h0000_00FF, 32'h0, 1'b0, 1'b0);
        tick();

        // Reset during MULTU after ten iteration steps.
        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_result_hi", 64'(result_hi), 64'd0);
        check("mid_rst_zero", 64'(zero), 64'd0);
        check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
        tick();
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (30) tick();
        check("mid_rst_no_stale_done", 64'(out_valid), 64'd0);
        issue(4'b0010, 32'd2, 32'd3);
        expect_out("add_after_rst", 32'd5, 32'd0, 1'b0, 1'b0);
        tick();

`ifdef ALU_SEQ_OVF_EN
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        check("ovf_add", 64'(ovf), 64'd1);
        check("ovf_add_result", 64'(result), 64'h8000_0000);
        tick();
        issue(4'b0110, 32'h8000_0000, 32'h0000_0001);
        check("ovf_sub", 64'(ovf), 64'd1);
        tick();
        issue(4'b0010, 32'd1, 32'd1);
        check("ovf_none", 64'(ovf), 64'd0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
